// File: rtl/delay_pipe_pkg.sv
// Shared constants and width helpers for the delay pipe.
// Imported by pipe_stage and delay_pipe.
package delay_pipe_pkg;

    localparam int          DEF_WIDTH     = 8;
    localparam int          DEF_DEPTH     = 4;
    localparam logic [63:0] DEF_RESET_VAL = 64'h0;

    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 64;
    localparam int MIN_DEPTH = 1;
    localparam int MAX_DEPTH = 32;

    // Tap select width; a single stage still gets one select bit.
    function automatic int tsw_f(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int occw_f(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/delay_pipe_stage.sv
// One data + valid register of the delay pipe.
// Flush outranks enable; reset outranks both.
module pipe_stage
    import delay_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             v_i,
    output logic [WIDTH-1:0] d_o,
    output logic             v_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush_i) begin
            data_d  = RESET_VAL;
            valid_d = 1'b0;
        end else if (en_i) begin
            data_d  = d_i;
            valid_d = v_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign d_o = data_q;
    assign v_o = valid_q;

endmodule

// File: rtl/delay_pipe.sv
// Parameterised delay line with per-stage valid bits, tap mux
// and a registered occupancy counter.
module delay_pipe
    import delay_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            din,
    input  logic                        din_valid,
    input  logic [tsw_f(DEPTH)-1:0]     tap_sel,
    output logic [WIDTH-1:0]            dout,
    output logic                        dout_valid,
    output logic [WIDTH-1:0]            tap_out,
    output logic                        tap_valid,
    output logic [occw_f(DEPTH)-1:0]    occ
);

    localparam int TSW  = tsw_f(DEPTH);
    localparam int OCCW = occw_f(DEPTH);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("delay_pipe: WIDTH must be in 1..64");
    end
    if (DEPTH < MIN_DEPTH || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("delay_pipe: DEPTH must be in 1..32");
    end

    logic [WIDTH-1:0] sd [DEPTH];
    logic [DEPTH-1:0] sv;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             v_in;
        if (i == 0) begin : g_head
            assign d_in = din;
            assign v_in = din_valid;
        end else begin : g_body
            assign d_in = sd[i-1];
            assign v_in = sv[i-1];
        end
        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (en),
            .flush_i (flush),
            .d_i     (d_in),
            .v_i     (v_in),
            .d_o     (sd[i]),
            .v_o     (sv[i])
        );
    end

    assign dout       = sd[DEPTH-1];
    assign dout_valid = sv[DEPTH-1];

    logic [OCCW-1:0] occ_q, occ_d;
    logic            inc, dec;

    assign inc = din_valid;
    assign dec = sv[DEPTH-1];

    // Guards keep the counter in 0..DEPTH even if the valid chain glitches.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (en) begin
            if (inc && !dec && occ_q != OCCW'(DEPTH)) begin
                occ_d = occ_q + OCCW'(1);
            end else if (!inc && dec && occ_q != '0) begin
                occ_d = occ_q - OCCW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;

    always_comb begin
        tap_out   = RESET_VAL;
        tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TSW'(i)) begin
                tap_out   = sd[i];
                tap_valid = sv[i];
            end
        end
    end

endmodule

// File: tb/tb_delay_pipe.sv
// Directed self-checking bench for delay_pipe across
// DEPTH 4, 3, 1 and 32 configurations.
module tb_delay_pipe;

    logic clk;
    logic rst;

    logic       en4, fl4, dv4;
    logic [7:0] din4;
    logic [1:0] ts4;
    logic [7:0] do4, to4;
    logic       dov4, tv4;
    logic [2:0] occ4;

    logic       en3, fl3, dv3;
    logic [7:0] din3;
    logic [1:0] ts3;
    logic [7:0] do3, to3;
    logic       dov3, tv3;
    logic [1:0] occ3;

    logic       en1, fl1, dv1;
    logic [7:0] din1;
    logic [0:0] ts1;
    logic [7:0] do1, to1;
    logic       dov1, tv1;
    logic [0:0] occ1;

    logic       en32, fl32, dv32;
    logic [7:0] din32;
    logic [4:0] ts32;
    logic [7:0] do32, to32;
    logic       dov32, tv32;
    logic [5:0] occ32;

    int n_chk;
    int n_fail;

    delay_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u4 (
        .clk(clk), .rst(rst), .en(en4), .flush(fl4),
        .din(din4), .din_valid(dv4), .tap_sel(ts4),
        .dout(do4), .dout_valid(dov4), .tap_out(to4),
        .tap_valid(tv4), .occ(occ4)
    );

    delay_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h5A)) u3 (
        .clk(clk), .rst(rst), .en(en3), .flush(fl3),
        .din(din3), .din_valid(dv3), .tap_sel(ts3),
        .dout(do3), .dout_valid(dov3), .tap_out(to3),
        .tap_valid(tv3), .occ(occ3)
    );

    delay_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u1 (
        .clk(clk), .rst(rst), .en(en1), .flush(fl1),
        .din(din1), .din_valid(dv1), .tap_sel(ts1),
        .dout(do1), .dout_valid(dov1), .tap_out(to1),
        .tap_valid(tv1), .occ(occ1)
    );

    delay_pipe #(.WIDTH(8), .DEPTH(32), .RESET_VAL(8'h00)) u32 (
        .clk(clk), .rst(rst), .en(en32), .flush(fl32),
        .din(din32), .din_valid(dv32), .tap_sel(ts32),
        .dout(do32), .dout_valid(dov32), .tap_out(to32),
        .tap_valid(tv32), .occ(occ32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_chk++;
        if (do4 !== 8'h00 || dov4 !== 1'b0 || occ4 !== 3'd0) begin
            $display("FAIL reset_d4: got %h/%b/%0d want 00/0/0", do4, dov4, occ4);
            n_fail++;
        end
        n_chk++;
        if (do3 !== 8'h5A || dov3 !== 1'b0 || occ3 !== 2'd0) begin
            $display("FAIL reset_d3: got %h/%b/%0d want 5a/0/0", do3, dov3, occ3);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_latency();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11;
        exp_d[1] = 8'h22;
        exp_d[2] = 8'h33;
        en4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din4 = exp_d[i];
            dv4  = 1'b1;
            tick();
        end
        din4 = 8'h00;
        dv4  = 1'b0;
        n_chk++;
        if (occ4 !== 3'd3 || dov4 !== 1'b0) begin
            $display("FAIL lat_fill: occ %0d dv %b want 3/0", occ4, dov4);
            n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (do4 !== exp_d[i] || dov4 !== 1'b1 || occ4 !== 3'(3 - i)) begin
                $display("FAIL lat_out%0d: got %h/%b/%0d want %h/1/%0d",
                         i, do4, dov4, occ4, exp_d[i], 3 - i);
                n_fail++;
            end
        end
        tick();
        n_chk++;
        if (dov4 !== 1'b0 || occ4 !== 3'd0) begin
            $display("FAIL lat_drain: dv %b occ %0d want 0/0", dov4, occ4);
            n_fail++;
        end
    endtask

    task automatic test_stall();
        en4  = 1'b1;
        din4 = 8'hA5;
        dv4  = 1'b1;
        tick();
        din4 = 8'h00;
        dv4  = 1'b0;
        tick();
        en4  = 1'b0;
        din4 = 8'hFF;
        dv4  = 1'b1;
        ts4  = 2'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++;
            if (occ4 !== 3'd1 || dov4 !== 1'b0 || to4 !== 8'hA5 || tv4 !== 1'b1) begin
                $display("FAIL stall_hold%0d: occ %0d dv %b tap %h/%b want 1/0/a5/1",
                         i, occ4, dov4, to4, tv4);
                n_fail++;
            end
        end
        en4  = 1'b1;
        din4 = 8'h00;
        dv4  = 1'b0;
        tick();
        n_chk++;
        if (dov4 !== 1'b0) begin
            $display("FAIL stall_early: dv %b want 0", dov4);
            n_fail++;
        end
        tick();
        n_chk++;
        if (do4 !== 8'hA5 || dov4 !== 1'b1 || occ4 !== 3'd1) begin
            $display("FAIL stall_out: got %h/%b/%0d want a5/1/1", do4, dov4, occ4);
            n_fail++;
        end
    endtask

    task automatic test_tap();
        en4 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            din4 = 8'(i);
            dv4  = 1'b1;
            tick();
        end
        en4  = 1'b0;
        dv4  = 1'b0;
        n_chk++;
        if (occ4 !== 3'd4) begin
            $display("FAIL tap_occ: got %0d want 4", occ4);
            n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            ts4 = 2'(i);
            #1;
            n_chk++;
            if (to4 !== 8'(4 - i) || tv4 !== 1'b1) begin
                $display("FAIL tap_sel%0d: got %h/%b want %h/1", i, to4, tv4, 4 - i);
                n_fail++;
            end
        end
    endtask

    task automatic test_flush();
        en4  = 1'b1;
        fl4  = 1'b1;
        din4 = 8'hFF;
        dv4  = 1'b1;
        ts4  = 2'd0;
        tick();
        fl4 = 1'b0;
        en4 = 1'b0;
        dv4 = 1'b0;
        n_chk++;
        if (occ4 !== 3'd0 || dov4 !== 1'b0 || do4 !== 8'h00) begin
            $display("FAIL flush_out: got %h/%b/%0d want 00/0/0", do4, dov4, occ4);
            n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            ts4 = 2'(i);
            #1;
            n_chk++;
            if (to4 !== 8'h00 || tv4 !== 1'b0) begin
                $display("FAIL flush_stage%0d: got %h/%b want 00/0", i, to4, tv4);
                n_fail++;
            end
        end
    endtask

    task automatic test_tap_oob();
        en3 = 1'b1;
        dv3 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            din3 = 8'h30 + 8'(i);
            tick();
        end
        en3 = 1'b0;
        dv3 = 1'b0;
        ts3 = 2'd3;
        #1;
        n_chk++;
        if (to3 !== 8'h5A || tv3 !== 1'b0) begin
            $display("FAIL tap_oob: got %h/%b want 5a/0", to3, tv3);
            n_fail++;
        end
        ts3 = 2'd2;
        #1;
        n_chk++;
        if (to3 !== 8'h31 || tv3 !== 1'b1 || occ3 !== 2'd3) begin
            $display("FAIL tap_last: got %h/%b/%0d want 31/1/3", to3, tv3, occ3);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        en3  = 1'b1;
        din3 = 8'h34;
        dv3  = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if (do3 !== 8'h5A || dov3 !== 1'b0 || occ3 !== 2'd0 || tv3 !== 1'b0) begin
            $display("FAIL async_rst: got %h/%b/%0d tv %b want 5a/0/0 tv 0",
                     do3, dov3, occ3, tv3);
            n_fail++;
        end
        #1;
        rst  = 1'b0;
        din3 = 8'hC3;
        dv3  = 1'b1;
        ts3  = 2'd0;
        tick();
        en3 = 1'b0;
        dv3 = 1'b0;
        n_chk++;
        if (to3 !== 8'hC3 || tv3 !== 1'b1 || occ3 !== 2'd1 || dov3 !== 1'b0) begin
            $display("FAIL rst_first: got %h/%b/%0d dv %b want c3/1/1 dv 0",
                     to3, tv3, occ3, dov3);
            n_fail++;
        end
    endtask

    task automatic test_depth1();
        en1 = 1'b1;
        dv1 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            din1 = 8'(i * 16);
            tick();
            n_chk++;
            if (do1 !== 8'(i * 16) || dov1 !== 1'b1 || occ1 !== 1'b1) begin
                $display("FAIL d1_step%0d: got %h/%b/%0d want %h/1/1",
                         i, do1, dov1, occ1, i * 16);
                n_fail++;
            end
        end
        en1 = 1'b0;
        dv1 = 1'b0;
    endtask

    task automatic test_depth32();
        en32 = 1'b1;
        dv32 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            din32 = 8'(i);
            tick();
            n_chk++;
            if (occ32 !== 6'(i + 1)) begin
                $display("FAIL d32_fill%0d: occ %0d want %0d", i, occ32, i + 1);
                n_fail++;
            end
        end
        n_chk++;
        if (do32 !== 8'h00 || dov32 !== 1'b1) begin
            $display("FAIL d32_first: got %h/%b want 00/1", do32, dov32);
            n_fail++;
        end
        for (int j = 0; j < 8; j++) begin
            din32 = 8'(32 + j);
            tick();
            n_chk++;
            if (occ32 !== 6'd32 || do32 !== 8'(j + 1) || dov32 !== 1'b1) begin
                $display("FAIL d32_steady%0d: got %h/%b/%0d want %h/1/32",
                         j, do32, dov32, occ32, j + 1);
                n_fail++;
            end
        end
        en32 = 1'b0;
        dv32 = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        en4 = 0; fl4 = 0; dv4 = 0; din4 = '0; ts4 = '0;
        en3 = 0; fl3 = 0; dv3 = 0; din3 = '0; ts3 = '0;
        en1 = 0; fl1 = 0; dv1 = 0; din1 = '0; ts1 = '0;
        en32 = 0; fl32 = 0; dv32 = 0; din32 = '0; ts32 = '0;
        test_reset();
        test_latency();
        test_stall();
        test_tap();
        test_flush();
        test_tap_oob();
        test_async_reset();
        test_depth1();
        test_depth32();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_pipe.md
DELAY_PIPE -- requirements
Module: delay_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data bits per stage; legal range 1 to 64.
REQ-002 Parameter DEPTH, default 4: number of pipeline stages; legal range 1 to 32.
REQ-003 Parameter RESET_VAL, default 0: WIDTH-bit value loaded into every stage data register at reset and flush.
REQ-004 The block SHALL have exactly one clock, `clk`, rising-edge: `clk`  in  1  clock.
REQ-005 `rst`  in  1  reset; asynchronous and active-high.
REQ-006 `en`  in  1  advance enable; when low, the pipe holds.
REQ-007 `flush`  in  1  synchronous clear of all valid bits.
REQ-008 `din`  in  WIDTH  input data.
REQ-009 `din_valid`  in  1  input data qualifier.
REQ-010 `tap_sel`  in  TSW  tap stage index, where TSW = max(1, clog2(DEPTH)).
REQ-011 `dout`  out  WIDTH  data of stage DEPTH-1 (registered).
REQ-012 `dout_valid`  out  1  valid bit of stage DEPTH-1.
REQ-013 `tap_out`  out  WIDTH  data of stage tap_sel (combinational mux of registers).
REQ-014 `tap_valid`  out  1  valid bit of stage tap_sel.
REQ-015 `occ`  out  clog2(DEPTH+1)  count of valid stages (registered).

Function
REQ-016 On a clk rising edge with en=1 and flush=0, the block SHALL perform the following updates:
- stage[0] data SHALL load din, and stage[0] valid SHALL load din_valid.
- stage[i] SHALL load stage[i-1] (data and valid) for each i in 1..DEPTH-1.
REQ-017 Data SHALL be captured regardless of din_valid; invalid stages are bubbles, and their data is don't-care to consumers.
REQ-018 With en=0 and flush=0, all stage data, valid bits and occ SHALL hold.
REQ-019 flush=1 SHALL take priority over en at the next edge:
- all valid bits SHALL clear, all stage data SHALL load RESET_VAL, and occ SHALL load 0.
- din is discarded, even when din_valid=1.
REQ-020 Latency: a word presented with en=1 at edge k SHALL appear on dout/dout_valid after edge k+DEPTH-1, provided en=1 on every intervening edge (DEPTH enabled edges total).
REQ-021 occ SHALL be a registered counter, not a recount of the valid bits. On an enabled, non-flush edge it SHALL update as occ + din_valid - valid[DEPTH-1]. It SHALL never exceed DEPTH or go below 0.
REQ-022 When tap_sel < DEPTH, tap_out/tap_valid SHALL equal stage[tap_sel] data/valid in the same cycle.
REQ-023 When tap_sel >= DEPTH, tap_out SHALL be RESET_VAL and tap_valid SHALL be 0.
REQ-024 For DEPTH=1: stage[0] is the output stage, tap_sel is 1 bit, and occ is 1 bit.
REQ-025 Simultaneous din_valid=1 with dout_valid=1 on an enabled edge SHALL leave occ unchanged.
REQ-026 Illegal parameter values SHALL cause an elaboration-time error, not silent truncation.

Reset
REQ-027 Assertion of rst SHALL immediately, without waiting for clk, force the following:
- all stage data to RESET_VAL;
- all valid bits to 0;
- occ to 0;
- hence dout=RESET_VAL and dout_valid=0.
REQ-028 rst SHALL take priority over flush and en.
REQ-029 rst asserted mid-stream SHALL discard all in-flight words.
REQ-030 After rst deassertion, the first enabled edge SHALL capture din normally.

Structure
REQ-031 Shared constants SHALL live in the team's shared parameter include:
- default WIDTH, DEPTH and RESET_VAL;
- the TSW derivation;
- the occ width derivation.
REQ-032 One sub-module, pipe_stage, SHALL implement a single WIDTH-bit data plus valid register with the following behaviour:
- async active-high reset to RESET_VAL/0;
- en and flush inputs.
REQ-033 delay_pipe SHALL instantiate DEPTH pipe_stage instances via generate.
REQ-034 The occ counter and the tap mux SHALL reside in delay_pipe.

Verification
REQ-035 Latency: WIDTH=8, DEPTH=4, en=1, din=0x11,0x22,0x33 valid on three consecutive edges -> dout=0x11 with dout_valid=1 after the 4th edge, then 0x22, then 0x33; occ reaches 3.
REQ-036 Stall: same config, 0xA5 valid, en low for 5 cycles after 2 edges -> dout unchanged during the stall; 0xA5 emerges after 4 enabled edges total; occ holds at 1 during the stall.
REQ-037 Flush vs enable: pipe full (occ=4), flush=1 with en=1 and din_valid=1 on the same edge -> occ=0, all valid=0, dout=RESET_VAL, din discarded.
REQ-038 Tap: fill with 0x01..0x04 -> tap_sel=0..3 returns 0x04,0x03,0x02,0x01 with tap_valid=1; DEPTH=3 with tap_sel=3 -> tap_out=RESET_VAL, tap_valid=0.
REQ-039 Async reset: assert rst mid-stream between clock edges with RESET_VAL=0x5A -> dout=0x5A, dout_valid=0, occ=0 before the next edge; first edge after deassertion captures din.
REQ-040 Occupancy boundary: DEPTH=1, continuous valid input -> occ stays 1 and dout tracks din one edge later; DEPTH=32 fill to occ=32 with steady-state in=out -> occ stays 32 and never wraps.
